// File: rtl/zjh_arb_pkg.sv
// Shared types and constants for the zjh mux arbiter: FSM states, widths, reset values.
package zjh_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StGrant,
    StGap
  } arb_state_e;

  localparam logic [SEL_W-1:0] SEL_RST  = '0;
  // Last starts at the top index so the first search begins at requester 0.
  localparam logic [SEL_W-1:0] LAST_RST = '1;

  function automatic logic [NUM_REQ-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    sel_onehot      = '0;
    sel_onehot[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/zjh_rr_pick.sv
// Combinational rotate-priority picker: first set request after Last, wrapping back to Last.
module zjh_rr_pick
  import zjh_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] Req,
  input  logic [SEL_W-1:0]   Last,
  output logic               Any,
  output logic [SEL_W-1:0]   Idx
);

  always_comb begin
    Any = |Req;
    Idx = Last;
    // Walk from farthest to nearest so the nearest set bit wins; k=4 wraps onto Last itself.
    for (int k = 4; k >= 1; k--) begin
      if (Req[Last + SEL_W'(k)]) begin
        Idx = Last + SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/zjh_mux_arbiter.sv
// Round-robin, break-before-make sequencer for a 4:1 active-low-enable mux.
// Optional hold timeout compiled in with ZJH_ARB_TIMEOUT_EN.
module zjh_mux_arbiter
  import zjh_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [NUM_REQ-1:0] Req,
  input  logic [NUM_REQ-1:0] DateIn,
  output logic [SEL_W-1:0]   Sel,
  output logic               Enable_n,
  output logic [NUM_REQ-1:0] Grant,
  output logic               DateOut,
  output logic               DateValid
);

  if (HOLD_MAX < 1) begin : g_hold_chk
    $error("HOLD_MAX must be at least 1");
  end

  arb_state_e         state_q;
  logic [SEL_W-1:0]   sel_q;
  logic [SEL_W-1:0]   last_q;
  logic               enable_n_q;
  logic [NUM_REQ-1:0] grant_q;
  logic               dout_q;
  logic               dvalid_q;

  logic               pick_any;
  logic [SEL_W-1:0]   pick_idx;
  logic               hold_done;

  zjh_rr_pick u_pick (
    .Req  (Req),
    .Last (last_q),
    .Any  (pick_any),
    .Idx  (pick_idx)
  );

`ifdef ZJH_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(HOLD_MAX + 1);

  logic [CntW-1:0] cnt_q;

  assign hold_done = (cnt_q == CntW'(HOLD_MAX - 1));

  // Held at zero outside GRANT, so every GRANT entry starts from a cleared count.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q <= '0;
    end else if (state_q == StGrant) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end
`else
  assign hold_done = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= StIdle;
      sel_q      <= SEL_RST;
      last_q     <= LAST_RST;
      enable_n_q <= 1'b1;
      grant_q    <= '0;
      dout_q     <= 1'b0;
      dvalid_q   <= 1'b0;
    end else begin
      enable_n_q <= 1'b1;
      grant_q    <= '0;
      dout_q     <= 1'b0;
      dvalid_q   <= 1'b0;
      unique case (state_q)
        StIdle, StGap: begin
          if (pick_any) begin
            sel_q   <= pick_idx;
            state_q <= StSetup;
          end else begin
            state_q <= StIdle;
          end
        end
        StSetup: begin
          if (Req[sel_q]) begin
            state_q    <= StGrant;
            last_q     <= sel_q;
            enable_n_q <= 1'b0;
            grant_q    <= sel_onehot(sel_q);
          end else begin
            state_q <= StIdle;
          end
        end
        StGrant: begin
          dout_q   <= DateIn[sel_q];
          dvalid_q <= 1'b1;
          if (Req[sel_q] && !hold_done) begin
            enable_n_q <= 1'b0;
            grant_q    <= sel_onehot(sel_q);
          end else begin
            state_q <= StGap;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign Sel       = sel_q;
  assign Enable_n  = enable_n_q;
  assign Grant     = grant_q;
  assign DateOut   = dout_q;
  assign DateValid = dvalid_q;

endmodule
